collatz_engine: RTL

Parametrised Collatz iteration engine with start handshake, step counting, overflow detection and a step-limit timeout. Loads a WIDTH-bit seed on `go`, applies one n/2 or 3n+1 step per clock, and reports the trajectory length, optional peak value and a terminal status. Standalone compute block for the lab datapath, driven by a simple controller or testbench.

---
 rtl/collatz_pkg.sv | 22 ++
 rtl/collatz_step.sv | 20 ++
 rtl/collatz_engine.sv | 119 +++++++++++
 3 files changed

// File: rtl/collatz_pkg.sv
// collatz_pkg: shared types and constants for the Collatz iteration engine.
//   state_t  - engine FSM states (IDLE / RUN / DONE)
//   status_t - terminal status codes reported on the status port
//   STATUS_W - width of the status port
package collatz_pkg;

    localparam int STATUS_W = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [STATUS_W-1:0] {
        ST_OK       = 2'd0,
        ST_ERR_ZERO = 2'd1,
        ST_OVERFLOW = 2'd2,
        ST_TIMEOUT  = 2'd3
    } status_t;

endpackage

// File: rtl/collatz_step.sv
// collatz_step: one combinational Collatz step.
//   cur  [WIDTH-1:0] in  - current value
//   next [WIDTH-1:0] out - cur/2 if even, else 3*cur+1 (low WIDTH bits)
//   ovf              out - 3*cur+1 does not fit in WIDTH bits
module collatz_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] next,
    output logic             ovf
);

    // 3*cur+1 needs at most two extra bits; 2*cur is built by concatenation.
    logic [WIDTH+1:0] triple;

    assign triple = {2'b00, cur} + {1'b0, cur, 1'b0} + (WIDTH+2)'(1);
    assign next   = cur[0] ? triple[WIDTH-1:0] : {1'b0, cur[WIDTH-1:1]};
    assign ovf    = cur[0] & (|triple[WIDTH+1:WIDTH]);

endmodule

// File: rtl/collatz_engine.sv
// collatz_engine: Collatz iteration engine, one step per clock.
// Optional feature macro: COLLATZ_PEAK_EN builds the peak tracker; without
// it the peak port is tied to 0.
// Ports:
//   clk, reset      - clock (rising edge), synchronous active-high reset
//   go, n           - start pulse and seed (n sampled only when go=1)
//   dout, steps     - current value and steps taken since load
//   peak            - largest value in the trajectory (incl. seed)
//   busy, done      - high in RUN / high in DONE
//   status          - OK / ERR_ZERO / OVERFLOW / TIMEOUT, valid while done
//   fsm_state       - current FSM state, for observation only
// Handshake: go is a level sampled every clock with no ready back-pressure;
// a cycle with go=1 always loads n, in every state, aborting any run in
// progress. done stays high until the next accepted go or reset.
module collatz_engine
    import collatz_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEPW = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                go,
    input  logic [WIDTH-1:0]    n,
    output logic [WIDTH-1:0]    dout,
    output logic [STEPW-1:0]    steps,
    output logic [WIDTH-1:0]    peak,
    output logic                busy,
    output logic                done,
    output logic [STATUS_W-1:0] status,
    output state_t              fsm_state
);

    localparam logic [STEPW-1:0] STEP_LIMIT = {STEPW{1'b1}};

    logic [WIDTH-1:0] next;
    logic             ovf;
    logic [STEPW-1:0] steps_inc;

    collatz_step #(.WIDTH(WIDTH)) u_step (
        .cur  (dout),
        .next (next),
        .ovf  (ovf)
    );

    assign steps_inc = steps + STEPW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_state <= S_IDLE;
            dout      <= '0;
            steps     <= '0;
            status    <= ST_OK;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (go) begin
            dout   <= n;
            steps  <= '0;
            status <= ST_OK;
            if (n == '0) begin
                fsm_state <= S_DONE;
                status    <= ST_ERR_ZERO;
                busy      <= 1'b0;
                done      <= 1'b1;
            end else if (n == WIDTH'(1)) begin
                fsm_state <= S_DONE;
                busy      <= 1'b0;
                done      <= 1'b1;
            end else begin
                fsm_state <= S_RUN;
                busy      <= 1'b1;
                done      <= 1'b0;
            end
        end else if (fsm_state == S_RUN) begin
            if (ovf) begin
                // dout/steps keep the last value that fit.
                fsm_state <= S_DONE;
                status    <= ST_OVERFLOW;
                busy      <= 1'b0;
                done      <= 1'b1;
            end else begin
                dout  <= next;
                steps <= steps_inc;
                // Reaching 1 wins over the step limit on the same step.
                if (next == WIDTH'(1)) begin
                    fsm_state <= S_DONE;
                    status    <= ST_OK;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                end else if (steps_inc == STEP_LIMIT) begin
                    fsm_state <= S_DONE;
                    status    <= ST_TIMEOUT;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                end
            end
        end
    end

`ifdef COLLATZ_PEAK_EN
    logic [WIDTH-1:0] peak_q;

    // Follows exactly the load/advance conditions of the FSM above.
    always_ff @(posedge clk) begin
        if (reset) begin
            peak_q <= '0;
        end else if (go) begin
            peak_q <= n;
        end else if (fsm_state == S_RUN && !ovf && next > peak_q) begin
            peak_q <= next;
        end
    end

    assign peak = peak_q;
`else
    assign peak = '0;
`endif

endmodule
